// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle for the two sources sharing the RF write port.
// master: requester side (valid/addr/data out, ready in); slave: arbiter side.
interface regfile_wb_arbiter_if #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32
);
  logic                   wb0_valid;
  logic [RF_ADDR_LEN-1:0] wb0_addr;
  logic [RF_DATA_LEN-1:0] wb0_data;
  logic                   wb0_ready;
  logic                   wb1_valid;
  logic [RF_ADDR_LEN-1:0] wb1_addr;
  logic [RF_DATA_LEN-1:0] wb1_data;
  logic                   wb1_ready;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (0)
// and LSU (1). Ports: clk, rst, flush, wb (slave bundle), w_en/rd_addr/
// rd_write_data to register_file, conflict_cnt (saturating contention count).
module regfile_wb_arbiter #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int CNT_LEN     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  regfile_wb_arbiter_if.slave    wb,
  output logic                   w_en,
  output logic [RF_ADDR_LEN-1:0] rd_addr,
  output logic [RF_DATA_LEN-1:0] rd_write_data,
  output logic [CNT_LEN-1:0]     conflict_cnt
);

  logic                   g0;
  logic                   g1;
  logic                   both;
  logic                   last_grant_q;
  logic                   last_grant_d;
  logic                   w_en_q;
  logic                   w_en_d;
  logic [RF_ADDR_LEN-1:0] rd_addr_q;
  logic [RF_ADDR_LEN-1:0] rd_addr_d;
  logic [RF_DATA_LEN-1:0] rd_data_q;
  logic [RF_DATA_LEN-1:0] rd_data_d;
  logic [CNT_LEN-1:0]     cnt_q;
  logic [CNT_LEN-1:0]     cnt_d;

  // Under contention the requester that did not win last is served.
  always_comb begin
    both = wb.wb0_valid & wb.wb1_valid;
    g0 = ~flush & wb.wb0_valid
       & (~wb.wb1_valid | last_grant_q);
    g1 = ~flush & wb.wb1_valid
       & (~wb.wb0_valid | ~last_grant_q);
  end

  assign wb.wb0_ready = g0;
  assign wb.wb1_ready = g1;

  always_comb begin
    last_grant_d = last_grant_q;
    w_en_d       = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    cnt_d        = cnt_q;
    unique case (1'b1)
      g0: begin
        last_grant_d = 1'b0;
        w_en_d       = |wb.wb0_addr;
        rd_addr_d    = wb.wb0_addr;
        rd_data_d    = wb.wb0_data;
      end
      g1: begin
        last_grant_d = 1'b1;
        w_en_d       = |wb.wb1_addr;
        rd_addr_d    = wb.wb1_addr;
        rd_data_d    = wb.wb1_data;
      end
      default: ;
    endcase
    if (both && cnt_q != {CNT_LEN{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      w_en_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      w_en_q       <= w_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign w_en          = w_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_write_data = rd_data_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed + random write-back
// traffic checked against a round-robin reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        w_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_write_data;
  logic [7:0]  conflict_cnt;

  regfile_wb_arbiter_if #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32)) wb ();

  regfile_wb_arbiter #(
    .RF_ADDR_LEN(5), .RF_DATA_LEN(32), .CNT_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb(wb),
    .w_en(w_en), .rd_addr(rd_addr),
    .rd_write_data(rd_write_data), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        r1;
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
    logic [7:0]  c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  int          m_pref;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  task automatic model_reset();
    m_pref = 0; m_wen = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  // Monitor: every cycle the DUT presents readies and registered outputs.
  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("wb0_ready", 32'(wb.wb0_ready), 32'(e.r0));
      check("wb1_ready", 32'(wb.wb1_ready), 32'(e.r1));
      check("w_en", 32'(w_en), 32'(e.wen));
      check("rd_addr", 32'(rd_addr), 32'(e.a));
      check("rd_write_data", rd_write_data, e.d);
      check("conflict_cnt", 32'(conflict_cnt), 32'(e.c));
    end
  end

  task automatic step(input logic f,
                      input logic v0, input logic [4:0] a0,
                      input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1,
                      input logic [31:0] d1,
                      output logic g0, output logic g1);
    exp_t x;
    @(posedge clk);
    #1;
    flush = f;
    wb.wb0_valid = v0; wb.wb0_addr = a0; wb.wb0_data = d0;
    wb.wb1_valid = v1; wb.wb1_addr = a1; wb.wb1_data = d1;
    g0 = 0; g1 = 0;
    if (!f) begin
      if (v0 && v1) begin
        g0 = (m_pref == 0);
        g1 = (m_pref == 1);
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    x.r0 = g0; x.r1 = g1; x.wen = m_wen;
    x.a = m_addr; x.d = m_data; x.c = 8'(m_cnt);
    q.push_back(x);
    if (g0) begin
      m_wen = (a0 != 0); m_addr = a0; m_data = d0; m_pref = 1;
    end else if (g1) begin
      m_wen = (a1 != 0); m_addr = a1; m_data = d1; m_pref = 0;
    end else begin
      m_wen = 0;
    end
    if (v0 && v1) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
  endtask

  logic        pv[2];
  logic [4:0]  pa[2];
  logic [31:0] pd[2];

  task automatic random_run(input int n);
    logic g0, g1, f;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && ($urandom % 4) != 0) begin
          pv[i] = 1;
          pa[i] = 5'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
      f = (($urandom % 8) == 0);
      step(f, pv[0], pa[0], pd[0], pv[1], pa[1], pd[1], g0, g1);
      if (g0) pv[0] = 0;
      if (g1) pv[1] = 0;
    end
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int k = 0; k < n; k++)
      step(0, 0, 0, 0, 0, 0, 0, g0, g1);
  endtask

  task automatic check_reset_outs();
    check("rst w_en", 32'(w_en), 0);
    check("rst rd_addr", 32'(rd_addr), 0);
    check("rst rd_write_data", rd_write_data, 0);
    check("rst conflict_cnt", 32'(conflict_cnt), 0);
  endtask

  initial begin
    logic g0, g1;
    int   guard;
    rst = 0; flush = 0;
    wb.wb0_valid = 0; wb.wb0_addr = 0; wb.wb0_data = 0;
    wb.wb1_valid = 0; wb.wb1_addr = 0; wb.wb1_data = 0;
    pv[0] = 0; pv[1] = 0;
    pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
    model_reset();
    #2 rst = 1;
    #1 check_reset_outs();
    @(negedge clk); #1 rst = 0;

    // Contention from reset: wb0 first, then wb1.
    step(0, 1, 5'd1, 32'd3, 1, 5'd9, 32'd27, g0, g1);
    step(0, 1, 5'd1, 32'd3, 1, 5'd9, 32'd27, g0, g1);
    idle(2);
    // Single requester.
    step(0, 1, 5'd8, 32'd24, 0, 0, 0, g0, g1);
    idle(2);
    // x0 write accepted without enabling the write port.
    step(0, 0, 0, 0, 1, 5'd0, 32'd3, g0, g1);
    idle(1);
    // Flush with contention, then pointer unchanged.
    step(1, 1, 5'd4, 32'd40, 1, 5'd5, 32'd50, g0, g1);
    step(1, 1, 5'd4, 32'd40, 1, 5'd5, 32'd50, g0, g1);
    step(0, 1, 5'd4, 32'd40, 1, 5'd5, 32'd50, g0, g1);
    idle(1);
    // Long contention: alternating grants and counter saturation.
    for (int k = 0; k < 300; k++)
      step(0, 1, 5'(k), 32'(k), 1, 5'(k + 7), 32'(~k), g0, g1);
    idle(1);
    random_run(400);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk); #1;
    rst = 1; flush = 0;
    wb.wb0_valid = 0; wb.wb1_valid = 0;
    pv[0] = 0; pv[1] = 0;
    #1 check_reset_outs();
    model_reset();
    @(negedge clk); #1 rst = 0;

    random_run(300);
    idle(2);

    guard = 0;
    while (q.size() > 1 && guard < 10) begin
      @(negedge clk); guard++;
    end
    check("scoreboard drained", 32'(q.size() <= 1), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
